// File: rtl/decode_stage_hs_pkg.sv
// decode_stage_hs_pkg: opcode/func constants, class codes and the per-instruction decode function.
// Shared by the decode stage top and its testbench-visible interface.
package decode_stage_hs_pkg;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_J   = 2'd2,
        CLS_ILL = 2'd3
    } cls_e;

    // Width-independent part of the decoded bundle; imm and pc are appended by the top.
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  func;
        logic [25:0] jtarget;
        logic [4:0]  wdst;
        logic        wr_en;
        cls_e        cls;
        logic        illegal;
    } dec_t;

    function automatic logic is_zext(input logic [5:0] op);
        return op == OP_ANDI || op == OP_ORI || op == OP_XORI;
    endfunction

    function automatic dec_t decode(input logic [31:0] instr, input logic [4:0] link);
        dec_t d;
        logic [5:0] op;
        logic wr;
        op = instr[31:26];
        d.opcode = op;
        d.rs = instr[25:21];
        d.rt = instr[20:16];
        d.rd = instr[15:11];
        d.func = instr[5:0];
        d.jtarget = instr[25:0];
        d.cls = CLS_ILL;
        wr = 1'b0;
        case (op)
            OP_R: begin
                d.cls = CLS_R;
                wr = instr[5:0] != FN_JR;
            end
            OP_J: d.cls = CLS_J;
            OP_JAL: begin
                d.cls = CLS_J;
                wr = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_SW: d.cls = CLS_I;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                d.cls = CLS_I;
                wr = 1'b1;
            end
            default: d.cls = CLS_ILL;
        endcase
        d.wdst = op == OP_R ? instr[15:11] : op == OP_JAL ? link : instr[20:16];
        d.illegal = d.cls == CLS_ILL;
        // Register 0 is hard-wired, so a write to it is suppressed here.
        d.wr_en = wr && d.wdst != 5'd0;
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_hs_if.sv
// decode_stage_hs_if: fetch-side and consumer-side handshake bundle of the decode stage.
// master drives instructions/out_ready/flush; slave is the decode stage.
interface decode_stage_hs_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_opcode;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_rd;
    logic [5:0]       out_func;
    logic [25:0]      out_jtarget;
    logic [XLEN-1:0]  out_imm;
    logic [4:0]       out_wdst;
    logic             out_wr_en;
    logic [1:0]       out_class;
    logic             out_illegal;
    logic [TAG_W-1:0] out_pc;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_func,
               out_jtarget, out_imm, out_wdst, out_wr_en, out_class, out_illegal, out_pc
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_func,
               out_jtarget, out_imm, out_wdst, out_wr_en, out_class, out_illegal, out_pc
    );
endinterface

// File: rtl/decode_skid_buf.sv
// decode_skid_buf: generic 2-entry valid/ready register stage (main + skid) of width W.
// in_ready depends only on the skid register and flush, never on out_ready.
module decode_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         push, load_main;

    always_comb begin
        in_ready = !skid_v_q && !flush;
        push = in_valid && in_ready;
        load_main = !main_v_q || out_ready;
        main_v_d = flush ? 1'b0 : load_main ? (skid_v_q || push) : main_v_q;
        main_d = load_main ? (skid_v_q ? skid_q : in_data) : main_q;
        // The skid register only fills when the main register is stuck holding.
        skid_v_d = flush ? 1'b0 : skid_v_q ? !load_main : (push && !load_main);
        skid_d = (!skid_v_q && push && !load_main) ? in_data : skid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign out_valid = main_v_q;
    assign out_data = main_q;
endmodule

// File: rtl/decode_stage_hs.sv
// decode_stage_hs: valid/ready instruction-decode stage (field slicing, imm extension, wdst, illegal).
// Define DECODE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module decode_stage_hs
    import decode_stage_hs_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LINK_REG = 31,
    parameter int TAG_W    = 32
) (
    input logic             clk,
    input logic             rst_n,
    decode_stage_hs_if.slave bus
);
    localparam int W = $bits(dec_t) + XLEN + TAG_W;

    dec_t            dec, o;
    logic [XLEN-1:0] imm;
    logic [W-1:0]    in_bundle, out_bundle;

    always_comb begin
        dec = decode(bus.in_instr, 5'(LINK_REG));
        imm = is_zext(bus.in_instr[31:26]) ? {{(XLEN-16){1'b0}}, bus.in_instr[15:0]}
                                           : {{(XLEN-16){bus.in_instr[15]}}, bus.in_instr[15:0]};
        in_bundle = {dec, imm, bus.in_pc};
    end

`ifdef DECODE_SKID_EN
    decode_skid_buf #(.W(W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_bundle),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_bundle)
    );
`else
    logic         valid_q, valid_d;
    logic [W-1:0] bundle_q, bundle_d;
    logic         push;

    always_comb begin
        bus.in_ready = (!valid_q || bus.out_ready) && !bus.flush;
        push = bus.in_valid && bus.in_ready;
        valid_d = bus.flush ? 1'b0 : push || (valid_q && !bus.out_ready);
        bundle_d = push ? in_bundle : bundle_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign out_bundle = bundle_q;
`endif

    assign {o, bus.out_imm, bus.out_pc} = out_bundle;
    assign bus.out_opcode = o.opcode;
    assign bus.out_rs = o.rs;
    assign bus.out_rt = o.rt;
    assign bus.out_rd = o.rd;
    assign bus.out_func = o.func;
    assign bus.out_jtarget = o.jtarget;
    assign bus.out_wdst = o.wdst;
    assign bus.out_wr_en = o.wr_en;
    assign bus.out_class = o.cls;
    assign bus.out_illegal = o.illegal;
endmodule

// File: tb/tb_decode_stage_hs.sv
// tb_decode_stage_hs: directed + random self-checking bench with a queue-based reference model.
module tb_decode_stage_hs;
`ifdef DECODE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, rd, wdst;
        logic [5:0]  func;
        logic [25:0] jt;
        logic [31:0] imm, pc;
        logic        wr, ill;
        logic [1:0]  cls;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    exp_t q[$];
    logic [31:0] pc_ctr = 32'h1000;

    always #5 clk = ~clk;

    decode_stage_hs_if #(.XLEN(32), .TAG_W(32)) bus ();

    decode_stage_hs #(.XLEN(32), .LINK_REG(31), .TAG_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic [5:0] op;
        logic legal, writes;
        op = i[31:26];
        legal = op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                           6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        e.opcode = op;
        e.rs = i[25:21];
        e.rt = i[20:16];
        e.rd = i[15:11];
        e.func = i[5:0];
        e.jt = i[25:0];
        e.pc = pc;
        e.ill = !legal;
        e.cls = !legal ? 2'd3 : op == 6'h00 ? 2'd0 : (op == 6'h02 || op == 6'h03) ? 2'd2 : 2'd1;
        e.imm = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, i[15:0]} : {{16{i[15]}}, i[15:0]};
        e.wdst = op == 6'h00 ? i[15:11] : op == 6'h03 ? 5'd31 : i[20:16];
        writes = (op == 6'h00 && i[5:0] != 6'h08) ||
                 (op inside {6'h03, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23});
        e.wr = legal && writes && e.wdst != 5'd0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bundle(input exp_t e);
        chk("opcode", 64'(bus.out_opcode), 64'(e.opcode));
        chk("rs", 64'(bus.out_rs), 64'(e.rs));
        chk("rt", 64'(bus.out_rt), 64'(e.rt));
        chk("rd", 64'(bus.out_rd), 64'(e.rd));
        chk("func", 64'(bus.out_func), 64'(e.func));
        chk("jtarget", 64'(bus.out_jtarget), 64'(e.jt));
        chk("imm", 64'(bus.out_imm), 64'(e.imm));
        chk("wdst", 64'(bus.out_wdst), 64'(e.wdst));
        chk("wr_en", 64'(bus.out_wr_en), 64'(e.wr));
        chk("class", 64'(bus.out_class), 64'(e.cls));
        chk("illegal", 64'(bus.out_illegal), 64'(e.ill));
        chk("pc", 64'(bus.out_pc), 64'(e.pc));
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic cycle(output bit acc);
        bit exp_rdy, push, pop;
        exp_t e;
        @(negedge clk);
        exp_rdy = !bus.flush && (CAP == 2 ? q.size() < 2 : (q.size() == 0 || bus.out_ready));
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) check_bundle(q[0]);
        push = bus.in_valid && exp_rdy;
        pop = q.size() > 0 && bus.out_ready;
        e = model(bus.in_instr, bus.in_pc);
        @(posedge clk);
        if (bus.flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        #1;
        acc = push;
    endtask

    task automatic offer(input logic [31:0] instr);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc = pc_ctr;
        pc_ctr = pc_ctr + 4;
    endtask

    initial begin
        bit acc;
        int n, idx;
        logic [31:0] stream[4];
        logic [5:0] ops[14];
        logic [31:0] flushed_pc;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        stream = '{32'h2108_0001, 32'h3509_1234, 32'h8D4A_FFF0, 32'h0000_5820};
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        offer(32'h2108_FFFF);
        // Reset held with an instruction offered
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        // ADDI sign-extension
        offer(32'h2108_FFFF);
        cycle(acc);
        bus.in_valid = 1'b0;
        chk("addi_imm", 64'(bus.out_imm), 64'hFFFF_FFFF);
        chk("addi_wdst", 64'(bus.out_wdst), 64'd8);
        chk("addi_wr_en", 64'(bus.out_wr_en), 64'd1);
        chk("addi_class", 64'(bus.out_class), 64'd1);
        // ORI zero-extension, then JAL
        offer(32'h3508_FFFF);
        cycle(acc);
        chk("ori_imm", 64'(bus.out_imm), 64'h0000_FFFF);
        offer(32'h0C00_0010);
        cycle(acc);
        bus.in_valid = 1'b0;
        chk("jal_wdst", 64'(bus.out_wdst), 64'd31);
        chk("jal_wr_en", 64'(bus.out_wr_en), 64'd1);
        chk("jal_jtarget", 64'(bus.out_jtarget), 64'h10);
        chk("jal_class", 64'(bus.out_class), 64'd2);
        // Illegal opcode and R-type writing $0
        offer(32'hFC00_0000);
        cycle(acc);
        chk("ill_flag", 64'(bus.out_illegal), 64'd1);
        chk("ill_class", 64'(bus.out_class), 64'd3);
        chk("ill_wr_en", 64'(bus.out_wr_en), 64'd0);
        offer(32'h0000_0020);
        cycle(acc);
        bus.in_valid = 1'b0;
        chk("rd0_wr_en", 64'(bus.out_wr_en), 64'd0);
        cycle(acc);
        // Back-pressure: 4 instructions, consumer stalled for 3 cycles
        bus.out_ready = 1'b0;
        idx = 0;
        n = 0;
        for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
            bus.out_ready = c >= 3;
            if (idx < 4) begin
                bus.in_valid = 1'b1;
                bus.in_instr = stream[idx];
                bus.in_pc = pc_ctr;
            end else bus.in_valid = 1'b0;
            cycle(acc);
            if (acc) begin
                idx++;
                pc_ctr = pc_ctr + 4;
                if (c < 3) n++;
            end
        end
        bus.in_valid = 1'b0;
        chk("stall_accepted", 64'(n), 64'(CAP));
        chk("stream_all_in", 64'(idx), 64'd4);
        chk("stream_drained", 64'(q.size()), 64'd0);
        // Flush with entries held and an instruction offered
        bus.out_ready = 1'b0;
        offer(32'h2002_0007);
        cycle(acc);
        offer(32'h2003_0008);
        cycle(acc);
        offer(32'h2004_0009);
        flushed_pc = bus.in_pc;
        bus.flush = 1'b1;
        cycle(acc);
        bus.flush = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_not_taken", 64'(acc), 64'd0);
        cycle(acc);
        chk("after_flush_taken", 64'(acc), 64'd1);
        chk("after_flush_pc", 64'(bus.out_pc), 64'(flushed_pc));
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cycle(acc);
        // Random traffic
        for (int c = 0; c < 400; c++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(3) != 0) r[31:26] = ops[$urandom_range(13)];
            bus.in_valid = $urandom_range(3) != 0;
            bus.in_instr = r;
            bus.in_pc = $urandom;
            bus.out_ready = $urandom_range(2) != 0;
            bus.flush = $urandom_range(19) == 0;
            cycle(acc);
        end
        bus.flush = 1'b0;
        // Asynchronous reset mid-transfer discards held entries
        bus.out_ready = 1'b0;
        offer(32'h2005_0001);
        cycle(acc);
        offer(32'h2006_0002);
        cycle(acc);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) cycle(acc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
